// File: rtl/hist_eq_seq.sv
// hist_eq_seq: histogram-equalisation mapper, round((cdf-cdf_min)*MAX_LVL/(PIXELS-cdf_min)) via restoring divider
module hist_eq_seq #(
  parameter int PIXELS = 76800,
  parameter int CDF_W  = 17,
  parameter int OUT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CDF_W-1:0] cdf,
  input  logic [CDF_W-1:0] cdf_min,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] pxl_out,
  output logic             out_clip,
  output logic             out_err
);
  localparam int NW = CDF_W + OUT_W + 2;
  localparam int CW = $clog2(OUT_W + 2);
  localparam logic [CDF_W-1:0] PIX = CDF_W'(PIXELS);
  localparam logic [OUT_W-1:0] MAX_LVL = '1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [NW-1:0] num_q, num_d, div_q, div_d, rem;
  logic [OUT_W:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, clip_q, clip_d, hi_q, hi_d;
  logic [OUT_W-1:0] pxl_q, pxl_d;
  logic out_clip_q, out_clip_d, out_err_q, out_err_d;
  logic [CDF_W-1:0] den, diff;
  logic lo, hi, err, fit;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign pxl_out   = pxl_q;
  assign out_clip  = out_clip_q;
  assign out_err   = out_err_q;
  always_comb begin
    err  = cdf_min >= PIX;
    lo   = cdf < cdf_min;
    hi   = cdf > PIX;
    den  = err ? '0 : PIX - cdf_min;
    diff = lo ? '0 : cdf - cdf_min;
    fit  = num_q >= div_q;
    rem  = fit ? num_q - div_q : num_q;
    state_d    = state_q;
    num_d      = num_q;
    div_d      = div_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    clip_d     = clip_q;
    hi_d       = hi_q;
    pxl_d      = pxl_q;
    out_clip_d = out_clip_q;
    out_err_d  = out_err_q;
    if (state_q == IDLE && in_valid) begin
      state_d = CALC;
      num_d   = ((NW'(diff) * NW'(MAX_LVL)) << 1) + NW'(den);
      div_d   = NW'(den) << (OUT_W + 1);
      quo_d   = '0;
      cnt_d   = CW'(OUT_W + 1);
      err_d   = err;
      clip_d  = !err && (lo || hi);
      hi_d    = !err && !lo && hi;
    end else if (state_q == CALC) begin
      num_d = rem;
      div_d = div_q >> 1;
      quo_d = {quo_q[OUT_W-1:0], fit};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d    = DONE;
        pxl_d      = err_q ? '0 : hi_q ? MAX_LVL : clip_q ? '0 : quo_d[OUT_W-1:0];
        out_clip_d = clip_q;
        out_err_d  = err_q;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      num_q      <= '0;
      div_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      clip_q     <= 1'b0;
      hi_q       <= 1'b0;
      pxl_q      <= '0;
      out_clip_q <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      div_q      <= div_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      clip_q     <= clip_d;
      hi_q       <= hi_d;
      pxl_q      <= pxl_d;
      out_clip_q <= out_clip_d;
      out_err_q  <= out_err_d;
    end
  end
endmodule

// File: tb/tb_hist_eq_seq.sv
// tb_hist_eq_seq: directed table plus random regression for hist_eq_seq, default and 10-bit configs
module tb_hist_eq_seq;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, out_clip, out_err;
  logic [16:0] cdf = 0, cdf_min = 0;
  logic [7:0] pxl_out;
  logic s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 1, s_out_clip, s_out_err;
  logic [10:0] s_cdf = 0, s_cdf_min = 0;
  logic [9:0] s_pxl_out;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  hist_eq_seq dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cdf(cdf),
    .cdf_min(cdf_min), .out_valid(out_valid), .out_ready(out_ready), .pxl_out(pxl_out),
    .out_clip(out_clip), .out_err(out_err));
  hist_eq_seq #(.PIXELS(1024), .CDF_W(11), .OUT_W(10)) u_small (.clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .cdf(s_cdf), .cdf_min(s_cdf_min),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .pxl_out(s_pxl_out),
    .out_clip(s_out_clip), .out_err(s_out_err));
  typedef struct { string nm; int c; int m; int p; bit cl; bit er; } vec_t;
  task automatic chk(input string nm, input longint a, input longint e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask
  function automatic void model(input longint c, input longint m, input longint pix, input int ow,
                                output longint p, output bit cl, output bit er);
    longint maxl = (longint'(1) << ow) - 1;
    longint den = pix - m;
    p = 0; cl = 0; er = 0;
    if (m >= pix) er = 1;
    else if (c < m) cl = 1;
    else if (c > pix) begin cl = 1; p = maxl; end
    else p = (2 * (c - m) * maxl + den) / (2 * den);
  endfunction
  // called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic txn(input string nm, input int c, input int m, input int stall,
                     input longint ep, input bit ec, input bit ee);
    int lat = 1;
    in_valid = 1; cdf = 17'(c); cdf_min = 17'(m);
    @(negedge clk);
    in_valid = 0; cdf = 17'($urandom); cdf_min = 17'($urandom);
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk({nm, "/latency"}, lat, 10);
    if (!out_valid) return;
    repeat (stall) begin out_ready = 0; @(negedge clk); end
    out_ready = 1;
    chk({nm, "/pxl"}, pxl_out, ep);
    chk({nm, "/clip"}, out_clip, ec);
    chk({nm, "/err"}, out_err, ee);
    chk({nm, "/in_ready_busy"}, in_ready, 0);
    @(negedge clk);
    chk({nm, "/release"}, {out_valid, in_ready}, 2'b01);
  endtask
  task automatic stxn(input string nm, input int c, input int m, input int stall);
    int lat = 1;
    longint ep;
    bit ec, ee;
    model(c, m, 1024, 10, ep, ec, ee);
    s_in_valid = 1; s_cdf = 11'(c); s_cdf_min = 11'(m);
    @(negedge clk);
    s_in_valid = 0; s_cdf = 11'($urandom); s_cdf_min = 11'($urandom);
    while (!s_out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk({nm, "/latency"}, lat, 12);
    if (!s_out_valid) return;
    repeat (stall) begin s_out_ready = 0; @(negedge clk); end
    s_out_ready = 1;
    chk({nm, "/pxl"}, s_pxl_out, ep);
    chk({nm, "/flags"}, {s_out_clip, s_out_err}, {ec, ee});
    @(negedge clk);
    chk({nm, "/release"}, {s_out_valid, s_in_ready}, 2'b01);
  endtask
  initial begin
    vec_t v[$];
    bit seen;
    longint ep;
    bit ec, ee;
    int c, m, r;
    v.push_back('{"round_up",   38450, 100,   128, 0, 0});
    v.push_back('{"full",       76800, 100,   255, 0, 0});
    v.push_back('{"at_min",     100,   100,   0,   0, 0});
    v.push_back('{"clip_lo",    50,    100,   0,   1, 0});
    v.push_back('{"clip_hi",    80000, 100,   255, 1, 0});
    v.push_back('{"err_eq",     76800, 76800, 0,   0, 1});
    v.push_back('{"err_gt",     0,     76801, 0,   0, 1});
    v.push_back('{"min0_one",   151,   0,     1,   0, 0});
    v.push_back('{"min0_zero",  1,     0,     0,   0, 0});
    v.push_back('{"den1_lo",    76799, 76799, 0,   0, 0});
    v.push_back('{"den1_hi",    76800, 76799, 255, 0, 0});
    v.push_back('{"clip_top",   131071, 0,    255, 1, 0});
    in_valid = 1; cdf = 17'd38450; cdf_min = 17'd100;
    repeat (3) begin @(negedge clk); chk("reset/out_valid", out_valid, 0); end
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk("reset/in_ready", in_ready, 1);
    chk("reset/outputs", {out_valid, pxl_out, out_clip, out_err}, 0);
    seen = 0;
    repeat (12) begin @(negedge clk); seen |= out_valid; end
    chk("reset/no_accept", seen, 0);
    foreach (v[i]) txn(v[i].nm, v[i].c, v[i].m, 0, v[i].p, v[i].cl, v[i].er);
    // backpressure with a competing in_valid that must be ignored
    in_valid = 1; cdf = 17'd38450; cdf_min = 17'd100;
    @(negedge clk);
    cdf = 17'd100; cdf_min = 17'd0;
    repeat (9) @(negedge clk);
    chk("bp/valid", out_valid, 1);
    out_ready = 0;
    repeat (6) begin
      @(negedge clk);
      chk("bp/hold", {out_valid, in_ready, pxl_out, out_clip, out_err}, {2'b10, 8'd128, 2'b00});
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("bp/release", {out_valid, in_ready}, 2'b01);
    seen = 0;
    repeat (12) begin @(negedge clk); seen |= out_valid; end
    chk("bp/single_transfer", seen, 0);
    // reset four cycles into a computation
    in_valid = 1; cdf = 17'd76800; cdf_min = 17'd100;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst/in_ready", in_ready, 1);
    seen = 0;
    repeat (15) begin @(negedge clk); seen |= out_valid; end
    chk("midrst/no_valid", seen, 0);
    txn("midrst/next", 38450, 100, 0, 128, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 9);
      m = (r == 0) ? $urandom_range(76800, 131071) : $urandom_range(0, 76799);
      c = (r == 1) ? $urandom_range(0, 131071) : $urandom_range(m, 76800);
      model(c, m, 76800, 8, ep, ec, ee);
      txn("rand", c, m, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0, ep, ec, ee);
    end
    stxn("small/full", 1024, 0, 0);
    stxn("small/clip_hi", 2000, 10, 2);
    stxn("small/err", 5, 1024, 0);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      m = (r == 0) ? $urandom_range(1024, 2047) : $urandom_range(0, 1023);
      c = (r == 1) ? $urandom_range(0, 2047) : $urandom_range(m, 1024);
      stxn("small/rand", c, m, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hist_eq_seq.md
# hist_eq_seq

Sequential, parametrised histogram-equalisation mapper for the post-decode image path. It takes one CDF value per transaction and computes round((cdf − cdf_min) · MAX_LVL / (PIXELS − cdf_min)) with an iterative restoring divider. Input and output use valid/ready handshakes, so it can sit between the CDF lookup RAM and the pixel writer. Unlike the earlier combinational mapper, frame size and output depth are parameters, rounding is built in, and degenerate cases are clipped and flagged.

## Interface
- PIXELS, 76800, pixels per frame (maximum CDF value)
- CDF_W, 17, width of cdf/cdf_min; must satisfy 2^CDF_W > PIXELS
- OUT_W, 8, output pixel width; MAX_LVL = 2^OUT_W − 1
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  cdf/cdf_min valid
- in_ready  out  1  block can accept (high only in IDLE)
- cdf  in  CDF_W  cumulative count for the pixel's level
- cdf_min  in  CDF_W  smallest non-zero CDF of the frame
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- pxl_out  out  OUT_W  equalised pixel
- out_clip  out  1  cdf < cdf_min or cdf > PIXELS; result was saturated
- out_err  out  1  cdf_min ≥ PIXELS (denominator ≤ 0); pxl_out forced to 0

## Operation
- States: IDLE, CALC, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE: an accept edge has in_valid && in_ready. On it the block registers:
  - num = 2·(cdf − cdf_min)·MAX_LVL + den, as unsigned of width CDF_W+OUT_W+2
  - den = PIXELS − cdf_min
  - the clip/err condition
  - iteration counter = OUT_W+1
  - then moves to CALC.
- CALC: one restoring-division step per cycle on divisor 2·den. Produces OUT_W+1 quotient bits, MSB first. When the counter reaches 0, moves to DONE.
- Result q = floor(num / (2·den)), which is round-half-up of the real ratio. q ≤ MAX_LVL whenever cdf_min ≤ cdf ≤ PIXELS; the stored value is q[OUT_W-1:0].
- Overrides, decided at accept time and applied on entry to DONE; latency is unchanged:
  - cdf_min ≥ PIXELS → pxl_out = 0, out_err = 1, out_clip = 0
  - else cdf < cdf_min → pxl_out = 0, out_clip = 1
  - else cdf > PIXELS → pxl_out = MAX_LVL, out_clip = 1
  - else out_clip = out_err = 0
- DONE: pxl_out, out_clip and out_err stay stable until out_valid && out_ready. On that edge the block returns to IDLE. in_ready rises the next cycle; there is no same-cycle re-accept.
- Input values are sampled only on the accept edge. Changes on cdf/cdf_min at any other time have no effect.
- All arithmetic is unsigned. The cdf − cdf_min subtraction is performed only when cdf ≥ cdf_min, so there is no wrap.

## Timing
- Reset values: state = IDLE, in_ready = 1 from the first cycle after reset, out_valid = 0, pxl_out = 0, out_clip = 0, out_err = 0, internal registers 0.
- rst takes priority in every state. Reset during CALC or DONE abandons the computation; no out_valid follows.
- Latency: out_valid is high after exactly OUT_W+2 rising edges counted from the accept edge (10 for OUT_W = 8).
- Throughput with out_ready tied high: one result per OUT_W+3 cycles.
- out_ready held low: DONE persists indefinitely with all outputs frozen, and in_ready stays 0.

## Test plan
- Reset: hold rst for 3 cycles with in_valid = 1 → out_valid = 0, pxl_out = 0, in_ready = 1 in the cycle after rst falls, nothing accepted during reset.
- Nominal and rounding: cdf = 38450, cdf_min = 100 → pxl_out = 128 (exact 127.5 rounds up), out_clip = 0, out_err = 0, out_valid high exactly 10 edges after accept. Then cdf = 76800, cdf_min = 100 → 255. Then cdf = 100, cdf_min = 100 → 0.
- Clip and error:
  - cdf = 50, cdf_min = 100 → 0, out_clip = 1
  - cdf = 80000, cdf_min = 100 → 255, out_clip = 1
  - cdf = 76800, cdf_min = 76800 → 0, out_err = 1
- Backpressure: out_ready = 0 for 6 cycles after out_valid → pxl_out/flags unchanged, in_ready = 0 throughout, a new in_valid is not accepted. Release → exactly one transfer, in_ready = 1 the following cycle.
- Reset mid-operation: assert rst 4 cycles after an accept → no out_valid ever appears for that input. The next transaction (cdf = 38450, cdf_min = 100) returns 128.
- Random regression: 2000 random cdf/cdf_min pairs with random out_ready stalls, checked against the reference model floor((2·(cdf − cdf_min)·255 + den) / (2·den)) plus the override rules. Also run OUT_W = 10, PIXELS = 1024, CDF_W = 11.
